// File: rtl/processor.sv
// Single-cycle RV32I-subset core with a 32x32 register file and combinational memory ports.
// Optional feature: define PROCESSOR_MUL_EN to execute the R-type mul encoding (otherwise a NOP).
module processor #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        write_enable,
    output logic [31:0] address_to_mem,
    output logic [31:0] data_to_mem,
    input  logic [31:0] data_from_mem
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_res, rd_wdata;
    logic        rd_we, mem_we, taken;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // x0 is never written and is cleared on reset, so reading the array directly yields 0.
    assign rs1_val = rf_q[rs1];
    assign rs2_val = rf_q[rs2];

    always_comb begin
        alu_res  = rs1_val + imm_i;
        rd_wdata = '0;
        rd_we    = 1'b0;
        mem_we   = 1'b0;
        taken    = 1'b0;
        pc_d     = pc_q + 32'd4;
        case (opcode)
            OP_R: begin
                rd_we = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'h0}: alu_res = rs1_val + rs2_val;
                    {7'h20, 3'h0}: alu_res = rs1_val - rs2_val;
                    {7'h00, 3'h1}: alu_res = rs1_val << rs2_val[4:0];
                    {7'h00, 3'h2}: alu_res = {31'b0, $signed(rs1_val) < $signed(rs2_val)};
                    {7'h00, 3'h4}: alu_res = rs1_val ^ rs2_val;
                    {7'h00, 3'h5}: alu_res = rs1_val >> rs2_val[4:0];
                    {7'h20, 3'h5}: alu_res = $unsigned($signed(rs1_val) >>> rs2_val[4:0]);
                    {7'h00, 3'h6}: alu_res = rs1_val | rs2_val;
                    {7'h00, 3'h7}: alu_res = rs1_val & rs2_val;
`ifdef PROCESSOR_MUL_EN
                    {7'h01, 3'h0}: alu_res = rs1_val * rs2_val;
`endif
                    default:       rd_we = 1'b0;
                endcase
                rd_wdata = alu_res;
            end
            OP_IMM: begin
                rd_we = 1'b1;
                case (funct3)
                    3'h0:    alu_res = rs1_val + imm_i;
                    3'h2:    alu_res = {31'b0, $signed(rs1_val) < $signed(imm_i)};
                    3'h4:    alu_res = rs1_val ^ imm_i;
                    3'h6:    alu_res = rs1_val | imm_i;
                    3'h7:    alu_res = rs1_val & imm_i;
                    default: rd_we = 1'b0;
                endcase
                rd_wdata = alu_res;
            end
            OP_LOAD: begin
                rd_we    = (funct3 == 3'h2);
                rd_wdata = data_from_mem;
            end
            OP_STORE: begin
                alu_res = rs1_val + imm_s;
                mem_we  = (funct3 == 3'h2);
            end
            OP_BRANCH: begin
                alu_res = rs1_val - rs2_val;
                case (funct3)
                    3'h0:    taken = (rs1_val == rs2_val);
                    3'h1:    taken = (rs1_val != rs2_val);
                    3'h4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
                    3'h5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
                    default: taken = 1'b0;
                endcase
                if (taken) pc_d = pc_q + imm_b;
            end
            OP_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OP_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OP_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + 32'd4;
                pc_d     = pc_q + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'h0) begin
                    rd_we    = 1'b1;
                    rd_wdata = pc_q + 32'd4;
                    pc_d     = alu_res & ~32'd1;
                end
            end
            default: ;
        endcase
        if (!reset) begin
            rd_we  = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            rf_d[i] = (rd_we && rd != 5'd0 && rd == 5'(i)) ? rd_wdata : rf_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign pc             = pc_q;
    assign write_enable   = mem_we;
    assign address_to_mem = alu_res;
    assign data_to_mem    = rs2_val;

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed architectural vectors followed by
// randomized instruction streams checked against a mnemonic-level reference model.
module tb_processor;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef PROCESSOR_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, instruction, address_to_mem, data_to_mem, data_from_mem;
    logic        write_enable;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_rf [32];
    logic        obs_we;
    logic [31:0] obs_addr, obs_data;

    typedef enum {
        M_NOP, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL, M_SRA, M_MUL,
        M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_LW, M_SW,
        M_BEQ, M_BNE, M_BLT, M_BGE, M_LUI, M_AUIPC, M_JAL, M_JALR
    } mnem_t;

    processor #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
        .write_enable(write_enable), .address_to_mem(address_to_mem),
        .data_to_mem(data_to_mem), .data_from_mem(data_from_mem)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2v,
                                          input logic [4:0] rs1v, input logic [2:0] f3,
                                          input logic [4:0] rdv);
        return {f7, rs2v, rs1v, f3, rdv, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1v,
                                          input logic [2:0] f3, input logic [4:0] rdv,
                                          input logic [6:0] op);
        return {imm[11:0], rs1v, f3, rdv, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2v,
                                          input logic [4:0] rs1v, input logic [2:0] f3);
        return {imm[11:5], rs2v, rs1v, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2v,
                                          input logic [4:0] rs1v, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2v, rs1v, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rdv);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rdv, 7'h6f};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rdv, input logic [4:0] rs1v,
                                         input logic [31:0] imm);
        return enc_i(imm, rs1v, 3'd0, rdv, 7'h13);
    endfunction

    function automatic mnem_t decode(input logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        case (op)
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: return M_ADD;  3'd1: return M_SLL; 3'd2: return M_SLT;
                        3'd4: return M_XOR;  3'd5: return M_SRL; 3'd6: return M_OR;
                        3'd7: return M_AND;  default: return M_NOP;
                    endcase
                end
                if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
                if (f7 == 7'h20 && f3 == 3'd5) return M_SRA;
                if (f7 == 7'h01 && f3 == 3'd0 && MUL_EN) return M_MUL;
                return M_NOP;
            end
            7'h13: begin
                case (f3)
                    3'd0: return M_ADDI; 3'd2: return M_SLTI; 3'd4: return M_XORI;
                    3'd6: return M_ORI;  3'd7: return M_ANDI; default: return M_NOP;
                endcase
            end
            7'h03: return (f3 == 3'd2) ? M_LW : M_NOP;
            7'h23: return (f3 == 3'd2) ? M_SW : M_NOP;
            7'h63: begin
                case (f3)
                    3'd0: return M_BEQ; 3'd1: return M_BNE; 3'd4: return M_BLT;
                    3'd5: return M_BGE; default: return M_NOP;
                endcase
            end
            7'h37: return M_LUI;
            7'h17: return M_AUIPC;
            7'h6f: return M_JAL;
            7'h67: return (f3 == 3'd0) ? M_JALR : M_NOP;
            default: return M_NOP;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    // One clock of stimulus: drive, check combinational outputs, clock, check pc.
    task automatic step(input logic [31:0] ins, input logic [31:0] dmem, input logic rst);
        mnem_t       m;
        logic [31:0] a, b, res, npc, exp_addr, im_i, im_s, im_b, im_u, im_j;
        logic        wr, exp_we, chk_addr;
        int          rdi;
        instruction   = ins;
        data_from_mem = dmem;
        reset         = rst;
        #1;
        m    = decode(ins);
        a    = m_rf[ins[19:15]];
        b    = m_rf[ins[24:20]];
        rdi  = int'(ins[11:7]);
        im_i = 32'($signed(ins[31:20]));
        im_s = 32'($signed({ins[31:25], ins[11:7]}));
        im_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        im_u = {ins[31:12], 12'h000};
        im_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        res = '0; wr = 1'b1; npc = m_pc + 4; exp_we = 1'b0; chk_addr = 1'b0; exp_addr = '0;
        case (m)
            M_ADD:   res = a + b;
            M_SUB:   res = a - b;
            M_AND:   res = a & b;
            M_OR:    res = a | b;
            M_XOR:   res = a ^ b;
            M_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            M_SLL:   res = a << (b % 32);
            M_SRL:   res = a >> (b % 32);
            M_SRA:   res = $unsigned($signed(a) >>> (b % 32));
            M_MUL:   res = a * b;
            M_ADDI:  res = a + im_i;
            M_ANDI:  res = a & im_i;
            M_ORI:   res = a | im_i;
            M_XORI:  res = a ^ im_i;
            M_SLTI:  res = ($signed(a) < $signed(im_i)) ? 32'd1 : 32'd0;
            M_LW:    begin res = dmem; chk_addr = 1'b1; exp_addr = a + im_i; end
            M_SW:    begin wr = 1'b0; exp_we = 1'b1; chk_addr = 1'b1; exp_addr = a + im_s; end
            M_BEQ:   begin wr = 1'b0; if (a == b) npc = m_pc + im_b; end
            M_BNE:   begin wr = 1'b0; if (a != b) npc = m_pc + im_b; end
            M_BLT:   begin wr = 1'b0; if ($signed(a) < $signed(b)) npc = m_pc + im_b; end
            M_BGE:   begin wr = 1'b0; if ($signed(a) >= $signed(b)) npc = m_pc + im_b; end
            M_LUI:   res = im_u;
            M_AUIPC: res = m_pc + im_u;
            M_JAL:   begin res = m_pc + 4; npc = m_pc + im_j; end
            M_JALR:  begin res = m_pc + 4; npc = (a + im_i) & 32'hFFFF_FFFE; end
            default: wr = 1'b0;
        endcase
        if (!rst) begin
            wr = 1'b0; exp_we = 1'b0; chk_addr = 1'b0;
        end
        obs_we   = write_enable;
        obs_addr = address_to_mem;
        obs_data = data_to_mem;
        check_eq("pc", pc, m_pc);
        check_eq("write_enable", {31'b0, write_enable}, {31'b0, exp_we});
        if (chk_addr) check_eq("address_to_mem", address_to_mem, exp_addr);
        if (exp_we) check_eq("data_to_mem", data_to_mem, b);
        @(posedge clk);
        #1;
        if (!rst) begin
            model_reset();
        end else begin
            if (wr && rdi != 0) m_rf[rdi] = res;
            m_pc = npc;
        end
        check_eq("pc_next", pc, m_pc);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 32; i++) check_eq($sformatf("x%0d", i), dut.rf_q[i], m_rf[i]);
    endtask

    logic [9:0] r_tbl [12] = '{
        {7'h00, 3'd0}, {7'h20, 3'd0}, {7'h00, 3'd1}, {7'h00, 3'd2}, {7'h00, 3'd3}, {7'h00, 3'd4},
        {7'h00, 3'd5}, {7'h20, 3'd5}, {7'h00, 3'd6}, {7'h00, 3'd7}, {7'h01, 3'd0}, {7'h20, 3'd1}
    };

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rdv  = 5'($urandom_range(0, 7));
        logic [4:0]  rs1v = 5'($urandom_range(0, 7));
        logic [4:0]  rs2v = 5'($urandom_range(0, 7));
        logic [2:0]  f3   = 3'($urandom_range(0, 7));
        logic [31:0] imm  = $urandom;
        logic [9:0]  sel;
        case ($urandom_range(0, 11))
            0, 1: begin sel = r_tbl[$urandom_range(0, 11)];
                        return enc_r(sel[9:3], rs2v, rs1v, sel[2:0], rdv); end
            2, 3: return enc_i(imm, rs1v, f3, rdv, 7'h13);
            4:    return enc_i(imm, rs1v, ($urandom_range(0, 3) == 0) ? f3 : 3'd2, rdv, 7'h03);
            5:    return enc_s(imm, rs2v, rs1v, ($urandom_range(0, 3) == 0) ? f3 : 3'd2);
            6:    return enc_b(imm, rs2v, rs1v, f3);
            7:    return {imm[31:12], rdv, 7'h37};
            8:    return {imm[31:12], rdv, 7'h17};
            9:    return enc_j(imm, rdv);
            10:   return enc_i(imm, rs1v, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rdv, 7'h67);
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        reset = 1'b0; instruction = NOP; data_from_mem = '0;
        @(posedge clk); #1;
        model_reset();

        // Boot: reset held, then first edge retires addi x1,x0,5 at RESET_PC.
        step(addi(1, 0, 5), 32'h0, 1'b0);
        check_eq("reset_pc", pc, 32'h0);
        step(addi(1, 0, 5), 32'h0, 1'b1);
        check_eq("boot_pc", pc, 32'h4);
        check_eq("boot_x1", dut.rf_q[1], 32'h5);

        // Control flow
        repeat (3) step(NOP, 32'h0, 1'b1);
        step(enc_b(-8, 0, 0, 3'd0), 32'h0, 1'b1);
        check_eq("beq_pc", pc, 32'h08);
        repeat (2) step(NOP, 32'h0, 1'b1);
        step(enc_b(-8, 0, 0, 3'd1), 32'h0, 1'b1);
        check_eq("bne_pc", pc, 32'h14);
        repeat (3) step(NOP, 32'h0, 1'b1);
        step(enc_j(16, 1), 32'h0, 1'b1);
        check_eq("jal_pc", pc, 32'h30);
        check_eq("jal_x1", dut.rf_q[1], 32'h24);
        step(addi(1, 0, 32'h40), 32'h0, 1'b1);
        step(enc_i(3, 1, 3'd0, 0, 7'h67), 32'h0, 1'b1);
        check_eq("jalr_pc", pc, 32'h42);

        // Shifts
        step(addi(2, 0, -1), 32'h0, 1'b1);
        step(addi(4, 0, 28), 32'h0, 1'b1);
        step(enc_r(7'h00, 4, 2, 3'd5, 3), 32'h0, 1'b1);
        check_eq("srl_x3", dut.rf_q[3], 32'h0000_000F);
        step(enc_r(7'h20, 4, 2, 3'd5, 3), 32'h0, 1'b1);
        check_eq("sra_x3", dut.rf_q[3], 32'hFFFF_FFFF);

        // Store then load
        step(addi(1, 0, 32'h100), 32'h0, 1'b1);
        step({20'hDEADC, 5'd5, 7'h37}, 32'h0, 1'b1);
        step(addi(5, 5, -273), 32'h0, 1'b1);
        step(enc_s(8, 5, 1, 3'd2), 32'h0, 1'b1);
        check_eq("sw_we", {31'b0, obs_we}, 32'h1);
        check_eq("sw_addr", obs_addr, 32'h108);
        check_eq("sw_data", obs_data, 32'hDEAD_BEEF);
        step(enc_i(8, 1, 3'd2, 6, 7'h03), 32'hDEAD_BEEF, 1'b1);
        check_eq("lw_we", {31'b0, obs_we}, 32'h0);
        check_eq("lw_addr", obs_addr, 32'h108);
        check_eq("lw_x6", dut.rf_q[6], 32'hDEAD_BEEF);

        // x0 immutability and unknown opcode
        step(addi(0, 0, 7), 32'h0, 1'b1);
        check_eq("x0_zero", dut.rf_q[0], 32'h0);
        step(32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        check_regs();

        // mul encoding
        step(addi(1, 0, 7), 32'h0, 1'b1);
        step(addi(2, 0, -3), 32'h0, 1'b1);
        step(addi(3, 0, 32'h55), 32'h0, 1'b1);
        step(enc_r(7'h01, 2, 1, 3'd0, 3), 32'h0, 1'b1);
`ifdef PROCESSOR_MUL_EN
        check_eq("mul_x3", dut.rf_q[3], 32'hFFFF_FFEB);
`else
        check_eq("mul_x3", dut.rf_q[3], 32'h55);
`endif

        // Reset mid-program aborts a store
        step(enc_s(8, 5, 1, 3'd2), 32'h0, 1'b0);
        check_eq("abort_we", {31'b0, obs_we}, 32'h0);
        check_eq("abort_pc", pc, RST_PC);
        check_regs();

        // Random streams with occasional reset
        for (int n = 0; n < 1500; n++) begin
            step(rand_instr(), $urandom, ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
            if (n % 100 == 99) check_regs();
        end
        check_regs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into pc on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-low reset (0 = reset), sampled only on rising clk.
REQ-004 pc  output  32  address of current instruction, registered.
REQ-005 instruction  input  32  instruction word at pc, combinational from instruction memory.
REQ-006 write_enable  output  1  data-memory write strobe, combinational.
REQ-007 address_to_mem  output  32  data-memory byte address, combinational.
REQ-008 data_to_mem  output  32  store data, combinational.
REQ-009 data_from_mem  input  32  load data, combinational read of address_to_mem.

Function
REQ-010 Single-cycle RV32I-subset core: one instruction retires per rising clk edge, standard RISC-V encodings.
REQ-011 Supported: add sub and or xor slt sll srl sra; addi andi ori xori slti; lw sw; beq bne blt bge; lui auipc; jal jalr.
REQ-012 Register file: 32 x 32 bit; two combinational read ports, one write port written on rising clk edge; x0 reads 0, writes to x0 discarded.
REQ-013 A register read in the same cycle as a write to it returns the old value; the new value is visible the next cycle.
REQ-014 Arithmetic: 32-bit two's-complement, wrap-around, no overflow trap; slt/slti/blt/bge signed.
REQ-015 Shifts use only the low 5 bits of rs2; sra sign-fills, srl zero-fills.
REQ-016 Immediates sign-extended per format (I, S, B, U, J); lui writes imm<<12; auipc writes pc+(imm<<12).
REQ-017 lw: address_to_mem = rs1+imm; rd <= data_from_mem at clock edge; write_enable = 0.
REQ-018 sw: address_to_mem = rs1+imm; data_to_mem = rs2; write_enable = 1 for that cycle only; no register write.
REQ-019 address_to_mem and data_to_mem are driven with the ALU result and rs2 for all instructions; meaningful only when write_enable = 1 or during lw.
REQ-020 Address low bits [1:0] passed through unmodified; memory is word-addressed; no misalignment detection.
REQ-021 Next pc: pc+4 default; branch taken -> pc+immB; jal -> pc+immJ; jalr -> (rs1+immI) & ~1; jal/jalr write pc+4 to rd (rd = rs1 in jalr uses the old rs1).
REQ-022 pc arithmetic wraps modulo 2^32.
REQ-023 Unsupported or unknown opcode/funct: executes as NOP (no register write, write_enable = 0, pc+4).

Reset
REQ-024 While reset = 0 at a rising edge: pc <= RESET_PC and x1..x31 <= 0.
REQ-025 While reset = 0, write_enable is forced 0 and no register write occurs.
REQ-026 Reset asserted mid-program aborts the current instruction with no architectural side effect; first instruction after release executes at RESET_PC.
REQ-027 Reset deasserted: first rising edge with reset = 1 retires the instruction at RESET_PC.

Configuration
REQ-028 Macro PROCESSOR_MUL_EN: when defined, R-type funct7=0000001 funct3=000 executes mul (low 32 bits of rs1*rs2 written to rd); when undefined, that encoding is a NOP per REQ-023.

Verification
REQ-029 Reset low 2 cycles then high, instruction = addi x1,x0,5 at 0 -> pc = 0 during reset, x1 = 5 and pc = 4 after first edge.
REQ-030 addi x2,x0,-1; srl x3,x2,x4 with x4=28 -> x3 = 0x0000000F; sra gives 0xFFFFFFFF.
REQ-031 x1=0x100, x5=0xDEADBEEF, sw x5,8(x1) -> write_enable = 1, address_to_mem = 0x108, data_to_mem = 0xDEADBEEF for exactly one cycle; subsequent lw x6,8(x1) with data_from_mem = 0xDEADBEEF -> x6 = 0xDEADBEEF.
REQ-032 beq x0,x0,-8 at pc 0x10 -> next pc 0x08; bne x0,x0,-8 -> 0x14; jal x1,16 at 0x20 -> pc 0x30, x1 = 0x24; jalr x0,3(x1) with x1=0x40 -> pc 0x42.
REQ-033 addi x0,x0,7 -> x0 still reads 0; undefined opcode 0x7F -> no state change except pc+4.
REQ-034 With PROCESSOR_MUL_EN, x1=7, x2=-3, mul x3,x1,x2 -> x3 = 0xFFFFFFEB; without it x3 unchanged.
